// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: ALU/LSU result handshakes, the register
// file write port and the decode-side scoreboard query/issue signals.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
);
  logic            i_alu_valid;
  logic            o_alu_ready;
  logic [IDXW-1:0] i_alu_rdidx;
  logic [XLEN-1:0] i_alu_wdata;
  logic            i_lsu_valid;
  logic            o_lsu_ready;
  logic [IDXW-1:0] i_lsu_rdidx;
  logic [XLEN-1:0] i_lsu_wdata;
  logic            o_rdwen;
  logic [IDXW-1:0] o_rdidx;
  logic [XLEN-1:0] o_rd_wdata;
  logic            i_issue_en;
  logic [IDXW-1:0] i_issue_rdidx;
  logic            i_flush;
  logic [IDXW-1:0] i_rs1idx;
  logic [IDXW-1:0] i_rs2idx;
  logic            o_rs1_busy;
  logic            o_rs2_busy;
  logic            o_idle;

  modport master (
    output i_alu_valid, i_alu_rdidx, i_alu_wdata,
    output i_lsu_valid, i_lsu_rdidx, i_lsu_wdata,
    output i_issue_en, i_issue_rdidx, i_flush, i_rs1idx, i_rs2idx,
    input  o_alu_ready, o_lsu_ready, o_rdwen, o_rdidx, o_rd_wdata,
    input  o_rs1_busy, o_rs2_busy, o_idle
  );

  modport slave (
    input  i_alu_valid, i_alu_rdidx, i_alu_wdata,
    input  i_lsu_valid, i_lsu_rdidx, i_lsu_wdata,
    input  i_issue_en, i_issue_rdidx, i_flush, i_rs1idx, i_rs2idx,
    output o_alu_ready, o_lsu_ready, o_rdwen, o_rdidx, o_rd_wdata,
    output o_rs1_busy, o_rs2_busy, o_idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter (ALU/LSU -> single RF write port) plus pending-write scoreboard.
// Define RF_WB_RR_EN for round-robin contention; default is fixed LSU-over-ALU priority.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
) (
  input logic            i_clk,
  input logic            i_rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 2**IDXW;

  logic            gnt_alu, gnt_lsu, gnt;
  logic [IDXW-1:0] sel_idx;
  logic [XLEN-1:0] sel_data;
  logic            wen_q;
  logic [IDXW-1:0] idx_q;
  logic [XLEN-1:0] data_q;
  logic [NREG-1:1] busy_q, busy_nxt;
  logic [NREG-1:0] busy_v;

`ifdef RF_WB_RR_EN
  // 1 = ALU took the last grant, so LSU wins the next contention
  logic last_alu;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)    last_alu <= 1'b1;
    else if (gnt) last_alu <= gnt_alu;

  assign gnt_lsu = bus.i_lsu_valid & (~bus.i_alu_valid |  last_alu);
  assign gnt_alu = bus.i_alu_valid & (~bus.i_lsu_valid | ~last_alu);
`else
  assign gnt_lsu = bus.i_lsu_valid;
  assign gnt_alu = bus.i_alu_valid & ~bus.i_lsu_valid;
`endif

  assign gnt      = gnt_alu | gnt_lsu;
  assign sel_idx  = gnt_lsu ? bus.i_lsu_rdidx : bus.i_alu_rdidx;
  assign sel_data = gnt_lsu ? bus.i_lsu_wdata : bus.i_alu_wdata;

  assign bus.o_alu_ready = gnt_alu;
  assign bus.o_lsu_ready = gnt_lsu;

  // x0 writes are accepted but never raise the write enable
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wen_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      wen_q <= gnt && (sel_idx != '0);
      if (gnt) begin
        idx_q  <= sel_idx;
        data_q <= sel_data;
      end
    end

  assign bus.o_rdwen    = wen_q;
  assign bus.o_rdidx    = idx_q;
  assign bus.o_rd_wdata = data_q;

  // Clear on write, then set on issue so a same-cycle set wins; flush beats both
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (wen_q && idx_q == IDXW'(r))                      busy_nxt[r] = 1'b0;
      if (bus.i_issue_en && bus.i_issue_rdidx == IDXW'(r)) busy_nxt[r] = 1'b1;
    end
    if (bus.i_flush) busy_nxt = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) busy_q <= '0;
    else       busy_q <= busy_nxt;

  assign busy_v = {busy_q, 1'b0};

  // The write landing this cycle is bypassed by the RF, so it does not stall decode
  assign bus.o_rs1_busy = busy_v[bus.i_rs1idx] & ~(wen_q && idx_q == bus.i_rs1idx);
  assign bus.o_rs2_busy = busy_v[bus.i_rs2idx] & ~(wen_q && idx_q == bus.i_rs2idx);
  assign bus.o_idle     = ~|busy_q & ~wen_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expectations follow RF_WB_RR_EN.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int IDXW = 5;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arbiter_if #(.XLEN(XLEN), .IDXW(IDXW)) bus ();

  rf_wb_arbiter #(.XLEN(XLEN), .IDXW(IDXW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

`ifdef RF_WB_RR_EN
  logic [2:0] c_lsu = 3'b101;
  logic [2:0] c_alu = 3'b010;
  logic [4:0] c_idx [3] = '{5'd4, 5'd3, 5'd4};
`else
  logic [2:0] c_lsu = 3'b111;
  logic [2:0] c_alu = 3'b000;
  logic [4:0] c_idx [3] = '{5'd4, 5'd4, 5'd4};
`endif

  initial begin
    bus.i_alu_valid = 0; bus.i_alu_rdidx = '0; bus.i_alu_wdata = '0;
    bus.i_lsu_valid = 0; bus.i_lsu_rdidx = '0; bus.i_lsu_wdata = '0;
    bus.i_issue_en = 0; bus.i_issue_rdidx = '0; bus.i_flush = 0;
    bus.i_rs1idx = '0; bus.i_rs2idx = '0;
    #1;
    chk("rst_rdwen", 32'(bus.o_rdwen), 0);
    chk("rst_rdidx", 32'(bus.o_rdidx), 0);
    chk("rst_wdata", bus.o_rd_wdata, 0);
    chk("rst_idle",  32'(bus.o_idle), 1);
    @(negedge i_clk); i_rst = 0;

    // lone ALU write
    bus.i_alu_valid = 1; bus.i_alu_rdidx = 5; bus.i_alu_wdata = 32'h1234;
    #1 chk("alu_ready", 32'(bus.o_alu_ready), 1);
    @(negedge i_clk); bus.i_alu_valid = 0;
    chk("alu_rdwen", 32'(bus.o_rdwen), 1);
    chk("alu_rdidx", 32'(bus.o_rdidx), 5);
    chk("alu_wdata", bus.o_rd_wdata, 32'h1234);
    @(negedge i_clk);
    chk("alu_rdwen_off", 32'(bus.o_rdwen), 0);
    chk("alu_rdidx_hold", 32'(bus.o_rdidx), 5);

    // contention for three cycles
    bus.i_alu_valid = 1; bus.i_alu_rdidx = 3; bus.i_alu_wdata = 32'hA;
    bus.i_lsu_valid = 1; bus.i_lsu_rdidx = 4; bus.i_lsu_wdata = 32'hB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("c_lsu_ready", 32'(bus.o_lsu_ready), 32'(c_lsu[k]));
      chk("c_alu_ready", 32'(bus.o_alu_ready), 32'(c_alu[k]));
      @(negedge i_clk);
      chk("c_rdwen", 32'(bus.o_rdwen), 1);
      chk("c_rdidx", 32'(bus.o_rdidx), 32'(c_idx[k]));
    end
    bus.i_alu_valid = 0; bus.i_lsu_valid = 0;
    @(negedge i_clk);

    // issue x7 then LSU writes it back
    bus.i_issue_en = 1; bus.i_issue_rdidx = 7; bus.i_rs1idx = 7;
    @(negedge i_clk); bus.i_issue_en = 0;
    chk("x7_busy", 32'(bus.o_rs1_busy), 1);
    chk("x7_idle", 32'(bus.o_idle), 0);
    bus.i_lsu_valid = 1; bus.i_lsu_rdidx = 7; bus.i_lsu_wdata = 32'h77;
    #1 chk("x7_lsu_ready", 32'(bus.o_lsu_ready), 1);
    @(negedge i_clk); bus.i_lsu_valid = 0;
    chk("x7_rdwen", 32'(bus.o_rdwen), 1);
    chk("x7_fwd_busy", 32'(bus.o_rs1_busy), 0);
    @(negedge i_clk);
    chk("x7_busy_after", 32'(bus.o_rs1_busy), 0);
    chk("x7_idle_after", 32'(bus.o_idle), 1);

    // same-cycle set and clear of x9: set wins
    bus.i_issue_en = 1; bus.i_issue_rdidx = 9; bus.i_rs1idx = 9;
    bus.i_lsu_valid = 1; bus.i_lsu_rdidx = 9; bus.i_lsu_wdata = 32'h99;
    @(negedge i_clk); bus.i_lsu_valid = 0;
    chk("x9_rdwen", 32'(bus.o_rdwen), 1);
    @(negedge i_clk); bus.i_issue_en = 0;
    chk("x9_busy", 32'(bus.o_rs1_busy), 1);

    // write to x0 is accepted and dropped
    bus.i_alu_valid = 1; bus.i_alu_rdidx = 0; bus.i_alu_wdata = 32'hFF; bus.i_rs1idx = 0;
    #1;
    chk("x0_ready", 32'(bus.o_alu_ready), 1);
    chk("x0_busy", 32'(bus.o_rs1_busy), 0);
    @(negedge i_clk); bus.i_alu_valid = 0;
    chk("x0_rdwen", 32'(bus.o_rdwen), 0);
    chk("x0_rdidx", 32'(bus.o_rdidx), 0);
    chk("x0_busy2", 32'(bus.o_rs1_busy), 0);

    // flush beats issue; the accepted LSU write still lands
    bus.i_issue_en = 1; bus.i_issue_rdidx = 2;
    @(negedge i_clk); bus.i_issue_rdidx = 3;
    @(negedge i_clk);
    bus.i_rs1idx = 2; bus.i_rs2idx = 3;
    #1;
    chk("fl_pre_rs1", 32'(bus.o_rs1_busy), 1);
    chk("fl_pre_rs2", 32'(bus.o_rs2_busy), 1);
    bus.i_flush = 1; bus.i_issue_rdidx = 6;
    bus.i_lsu_valid = 1; bus.i_lsu_rdidx = 12; bus.i_lsu_wdata = 32'hC;
    #1 chk("fl_lsu_ready", 32'(bus.o_lsu_ready), 1);
    @(negedge i_clk);
    bus.i_flush = 0; bus.i_issue_en = 0; bus.i_lsu_valid = 0;
    #1;
    chk("fl_rdwen", 32'(bus.o_rdwen), 1);
    chk("fl_rdidx", 32'(bus.o_rdidx), 12);
    chk("fl_rs1", 32'(bus.o_rs1_busy), 0);
    chk("fl_rs2", 32'(bus.o_rs2_busy), 0);
    bus.i_rs1idx = 6; bus.i_rs2idx = 9;
    #1;
    chk("fl_x6", 32'(bus.o_rs1_busy), 0);
    chk("fl_x9", 32'(bus.o_rs2_busy), 0);
    @(negedge i_clk);
    chk("fl_idle", 32'(bus.o_idle), 1);

    // reset mid-operation drops the pending write and the scoreboard
    bus.i_issue_en = 1; bus.i_issue_rdidx = 5; bus.i_rs1idx = 5;
    bus.i_lsu_valid = 1; bus.i_lsu_rdidx = 10; bus.i_lsu_wdata = 32'hAB;
    @(negedge i_clk);
    bus.i_issue_en = 0; bus.i_lsu_valid = 0;
    chk("mr_rdwen_pre", 32'(bus.o_rdwen), 1);
    chk("mr_busy_pre", 32'(bus.o_rs1_busy), 1);
    #2 i_rst = 1;
    #1;
    chk("mr_rdwen", 32'(bus.o_rdwen), 0);
    chk("mr_busy", 32'(bus.o_rs1_busy), 0);
    chk("mr_idle", 32'(bus.o_idle), 1);
    @(negedge i_clk); i_rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
